store_buffer: RTL
=================

# store_buffer

Posted-write buffer between the core's data-memory port and data memory. It accepts stores from the core in one cycle each and queues them in a small FIFO. The queued stores are drained to memory over a req/ack handshake, so a slow or multi-cycle data memory never needs to stall the single-cycle core. Loads are checked against the queued stores and forwarded from the buffer, so the core always reads the latest value.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- MemWrite  in  1  core store strobe
- DataAdr  in  32  core address; used for both stores and loads
- WriteData  in  32  core store data
- MemRData  in  32  data memory asynchronous read data at DataAdr
- ReadData  out  32  load data to core, forwarded or MemRData
- MemReq  out  1  drain request to memory
- MemAck  in  1  memory accepts write at this edge when MemReq=1
- MemAdr  out  32  drain word address; low 2 bits always 00
- MemWData  out  32  drain data
- Full  out  1  count == DEPTH
- Empty  out  1  count == 0
- Overflow  out  1  sticky; a store was dropped

## Operation
- Entry contents: {word address DataAdr[31:2], data}, plus a valid bit.
- Head and tail pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Enqueue when MemWrite=1 and either count<DEPTH or a dequeue occurs in the same cycle. When full with no dequeue, the store is dropped and Overflow is set. Overflow clears only on reset.
- Dequeue occurs when MemReq & MemAck at the edge. MemAck is ignored while MemReq=0.
- Drain FSM:
  - IDLE: MemReq=0. If count>0, load the head into the MemAdr/MemWData registers and go to REQ.
  - REQ: MemReq=1. MemAdr/MemWData stay stable until ack. On ack, pop the head. If entries remain (counting a same-cycle enqueue), load the new head and stay in REQ; otherwise go to IDLE.
- The in-flight entry stays in the FIFO until acked, so it remains visible to forwarding.
- Forwarding is combinational. DataAdr[31:2] is compared against all valid entries; the youngest match wins.
  - Hit: ReadData = entry data.
  - Miss: ReadData = MemRData.
  - A store presented in the current cycle is not forwarded in that same cycle.
- Stores drain in program order. Two stores to the same address both drain; there is no merging.
- Reset values: count=0, pointers=0, all valid bits=0, state=IDLE, MemReq=0, MemAdr=0, MemWData=0, Full=0, Empty=1, Overflow=0.

## Timing
- Store sampled at edge e0 → Empty=0 after e0 → state REQ and MemReq=1 after e1 → written at the first edge where MemAck=1 (e2 at the earliest).
- Minimum store-to-memory latency is 2 edges. With MemAck tied high, sustained drain rate is one store per cycle.
- Forwarding adds zero cycles: ReadData is valid in the same cycle as DataAdr.
- Full and Empty are derived from the registered count, so they are valid right after each edge.
- A dequeue and an enqueue at the same edge leave count unchanged, including when full.
- Reset asserted mid-handshake takes effect asynchronously: MemReq drops immediately and all queued stores are discarded. The memory must not treat an unfinished handshake as a write.

## Test plan
- Single store: after reset, MemWrite with DataAdr=0x64, WriteData=7, MemAck=1 → MemReq=1 one cycle after the store, MemAdr=0x64, MemWData=7; Empty=1 after the ack edge.
- Forwarding: MemAck=0; stores 0x60←3, then 0x60←5, then 0x64←9.
  - DataAdr=0x60 → ReadData=5.
  - DataAdr=0x64 → ReadData=9.
  - DataAdr=0x68 with MemRData=0xAA → ReadData=0xAA.
- Fill and overflow: MemAck=0; five stores to 0x00, 0x04, 0x08, 0x0C, 0x10 → Full=1 after the fourth; the fifth is dropped; Overflow=1. Then MemAck=1 → writes to 0x00, 0x04, 0x08, 0x0C on consecutive edges; 0x10 never appears; Overflow stays 1.
- Full with same-cycle dequeue: buffer full, MemAck=1 and MemWrite to 0x20 at the same edge → store accepted, Full stays 1, Overflow stays 0, and 0x20 drains last.
- Reset mid-operation: three entries queued and MemReq=1, then reset low for half a cycle → MemReq=0 and Empty=1 immediately. Released with no stores → MemReq stays 0.
- Wrap-around: 10 stores with a random MemAck pattern (count never exceeding 4) → memory receives all 10 in order with correct data, and forwarding stays correct across pointer wrap.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load forwarding
//
// Queues core stores in a DEPTH-entry FIFO and drains them to data memory
// over a MemReq/MemAck handshake. Loads are forwarded from the youngest
// matching queued store, otherwise MemRData is passed through.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   MemWrite, DataAdr,
//   WriteData                  core store strobe, address, data
//   ReadData                   load data to core (forwarded or MemRData)
//   MemRData                   memory asynchronous read data at DataAdr
//   MemReq, MemAck             drain handshake
//   MemAdr, MemWData           drain word address (low bits 00) and data
//   Full, Empty, Overflow      occupancy flags; Overflow is sticky
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [31:0] MemRData,
  output logic [31:0] ReadData,
  output logic        MemReq,
  input  logic        MemAck,
  output logic [31:0] MemAdr,
  output logic [31:0] MemWData,
  output logic        Full,
  output logic        Empty,
  output logic        Overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, tail_q, head_nxt;
  logic [AW:0]     count_q, count_d;
  logic [29:0]     adr_q  [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [29:0]     mem_adr_q, mem_adr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            overflow_q;
  logic            deq, enq;
  logic [AW-1:0]   fwd_idx;

  assign Full     = (count_q == (AW+1)'(DEPTH));
  assign Empty    = (count_q == '0);
  assign Overflow = overflow_q;
  assign MemReq   = (state_q == REQ);
  assign MemAdr   = {mem_adr_q, 2'b00};
  assign MemWData = mem_wdata_q;

  assign deq      = MemReq && MemAck;
  // A full buffer still accepts a store when the head leaves at the same edge.
  assign enq      = MemWrite && (!Full || deq);
  assign head_nxt = head_q + AW'(1);

  always_comb begin
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + (AW+1)'(1);
    end else if (deq && !enq) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (!Empty) begin
          mem_adr_d   = adr_q[head_q];
          mem_wdata_d = data_q[head_q];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (deq) begin
          if (count_q > (AW+1)'(1)) begin
            mem_adr_d   = adr_q[head_nxt];
            mem_wdata_d = data_q[head_nxt];
          end else if (enq) begin
            // Last entry leaves while a store arrives: that store becomes the
            // new head before it is even written into the array.
            mem_adr_d   = DataAdr[31:2];
            mem_wdata_d = WriteData;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    ReadData = MemRData;
    fwd_idx  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + AW'(i);
      if (valid_q[fwd_idx] && (adr_q[fwd_idx] == DataAdr[31:2])) begin
        ReadData = data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_nxt;
      end
      // Placed after the dequeue so a full-buffer push into the slot being
      // freed leaves its valid bit set.
      if (enq) begin
        adr_q[tail_q]   <= DataAdr[31:2];
        data_q[tail_q]  <= WriteData;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + AW'(1);
      end
      if (MemWrite && !enq) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
